// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the pipeline run-control sequencer: the FSM state
// encoding exposed on the debug readout, plus a small classification helper.
package pipeline_sequencer_pkg;

  localparam int SEQ_STATE_W = 3;

  // Codes 5-7 are never produced; the FSM steers them back to SEQ_IDLE.
  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_RUN   = 3'd1,
    SEQ_STEP  = 3'd2,
    SEQ_DRAIN = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_e;

  // True while the pipeline is moving (the cycle counter advances in these states).
  function automatic logic seq_is_busy(input seq_state_e s);
    return (s == SEQ_RUN) || (s == SEQ_STEP) || (s == SEQ_DRAIN);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_q;

  // Count up on i_inc, stop at the maximum value instead of wrapping.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_clr) begin
      count_q <= '0;
    end else if (i_inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control FSM for the 5-stage pipeline. Turns debug run/step commands and
// hazard-unit requests into pipeline-register enables and flushes, drains the
// back end after HALT, and counts cycles in which the pipeline advanced.
// Handshake note: i_run/i_step are single-cycle command pulses sampled every
// clock; i_step is edge-qualified so a held level yields only one step.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_hz_stall,
  input  logic             i_hz_flush_if_id,
  input  logic             i_hz_flush_id_ex,
  input  logic             i_hz_halt,
  output logic             o_pc_we,
  output logic             o_if_id_we,
  output logic             o_if_id_flush,
  output logic             o_id_ex_we,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_we,
  output logic             o_mem_wb_we,
  output logic             o_busy,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [2:0]       o_state
);

  localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  seq_state_e    state_q;
  logic [DW-1:0] drain_q;
  logic          halted_q;
  logic          step_prev_q;
  logic          step_edge;
  logic          advance;
  logic          draining;

  // A step only counts on its rising edge so a held button cannot re-trigger.
  assign step_edge = i_step & ~step_prev_q;

  // Run-control FSM with the drain countdown and sticky halted flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= SEQ_IDLE;
      drain_q     <= '0;
      halted_q    <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= i_step;
      case (state_q)
        SEQ_IDLE: begin
          if (i_run) begin
            state_q <= SEQ_RUN;
          end else if (step_edge) begin
            state_q <= SEQ_STEP;
          end
        end
        SEQ_RUN: begin
          if (i_hz_halt) begin
            state_q <= SEQ_DRAIN;
            drain_q <= DRAIN_LOAD;
          end
        end
        SEQ_STEP: begin
          if (i_hz_halt) begin
            state_q <= SEQ_DRAIN;
            drain_q <= DRAIN_LOAD;
          end else begin
            state_q <= SEQ_IDLE;
          end
        end
        SEQ_DRAIN: begin
          if (drain_q == '0) begin
            state_q  <= SEQ_DONE;
            halted_q <= 1'b1;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        SEQ_DONE: begin
          state_q <= SEQ_DONE;
        end
        default: begin
          state_q  <= SEQ_IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline enables/flushes decoded from the registered state and live hazards.
  always_comb begin
    advance       = (state_q == SEQ_RUN) || (state_q == SEQ_STEP);
    draining      = (state_q == SEQ_DRAIN);
    o_pc_we       = 1'b0;
    o_if_id_we    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_we    = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_mem_we   = 1'b0;
    o_mem_wb_we   = 1'b0;
    if (advance) begin
      o_pc_we       = ~i_hz_stall;
      o_if_id_we    = ~i_hz_stall;
      o_if_id_flush = i_hz_flush_if_id;
      o_id_ex_we    = 1'b1;
      o_id_ex_flush = i_hz_flush_id_ex;
      o_ex_mem_we   = 1'b1;
      o_mem_wb_we   = 1'b1;
    end else if (draining) begin
      // Front end frozen, bubbles pushed into ID/EX while the back end retires.
      o_id_ex_we    = 1'b1;
      o_id_ex_flush = 1'b1;
      o_ex_mem_we   = 1'b1;
      o_mem_wb_we   = 1'b1;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (seq_is_busy(state_q)),
    .i_clr   (1'b0),
    .o_count (o_cycle_count)
  );

  assign o_busy   = seq_is_busy(state_q);
  assign o_halted = halted_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  localparam int DRAIN_CYCLES = 3;

  // ---------------- clock / reset / DUT ----------------
  logic i_clk = 1'b0;
  logic i_reset, i_run, i_step, i_hz_stall, i_hz_flush_if_id, i_hz_flush_id_ex, i_hz_halt;

  always #5 i_clk = ~i_clk;

  logic        o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_we, o_id_ex_flush;
  logic        o_ex_mem_we, o_mem_wb_we, o_busy, o_halted;
  logic [31:0] o_cycle_count;
  logic [2:0]  o_state;

  logic        s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_we, s_id_ex_flush;
  logic        s_ex_mem_we, s_mem_wb_we, s_busy, s_halted;
  logic [3:0]  s_cycle_count;
  logic [2:0]  s_state;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_hz_stall(i_hz_stall), .i_hz_flush_if_id(i_hz_flush_if_id),
    .i_hz_flush_id_ex(i_hz_flush_id_ex), .i_hz_halt(i_hz_halt),
    .o_pc_we(o_pc_we), .o_if_id_we(o_if_id_we), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_we(o_id_ex_we), .o_id_ex_flush(o_id_ex_flush), .o_ex_mem_we(o_ex_mem_we),
    .o_mem_wb_we(o_mem_wb_we), .o_busy(o_busy), .o_halted(o_halted),
    .o_cycle_count(o_cycle_count), .o_state(o_state)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(4)) dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_hz_stall(i_hz_stall), .i_hz_flush_if_id(i_hz_flush_if_id),
    .i_hz_flush_id_ex(i_hz_flush_id_ex), .i_hz_halt(i_hz_halt),
    .o_pc_we(s_pc_we), .o_if_id_we(s_if_id_we), .o_if_id_flush(s_if_id_flush),
    .o_id_ex_we(s_id_ex_we), .o_id_ex_flush(s_id_ex_flush), .o_ex_mem_we(s_ex_mem_we),
    .o_mem_wb_we(s_mem_wb_we), .o_busy(s_busy), .o_halted(s_halted),
    .o_cycle_count(s_cycle_count), .o_state(s_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit     running;
    bit     stepping;
    bit     done;
    bit     step_prev;
    int     drain_left;
    longint cnt;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t c, input bit run, input bit step,
                                        input bit halt);
    model_t n = c;
    n.step_prev = step;
    if (c.done) begin
      // stuck until reset
    end else if (c.drain_left > 0) begin
      n.cnt = c.cnt + 1;
      n.drain_left = c.drain_left - 1;
      if (n.drain_left == 0) n.done = 1'b1;
    end else if (c.running) begin
      n.cnt = c.cnt + 1;
      if (halt) begin
        n.running = 1'b0;
        n.drain_left = DRAIN_CYCLES;
      end
    end else if (c.stepping) begin
      n.cnt = c.cnt + 1;
      n.stepping = 1'b0;
      if (halt) n.drain_left = DRAIN_CYCLES;
    end else if (run) begin
      n.running = 1'b1;
    end else if (step && !c.step_prev) begin
      n.stepping = 1'b1;
    end
    return n;
  endfunction

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) m <= '0;
    else         m <= model_next(m, i_run, i_step, i_hz_halt);
  end

  logic        e_adv, e_drn;
  logic [2:0]  e_state;
  logic [31:0] e_cnt32, e_cnt4;
  assign e_adv   = (m.running || m.stepping) && (m.drain_left == 0) && !m.done;
  assign e_drn   = (m.drain_left > 0);
  assign e_state = m.done ? 3'd4 : e_drn ? 3'd3 : m.stepping ? 3'd2 : m.running ? 3'd1 : 3'd0;
  assign e_cnt32 = (m.cnt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m.cnt[31:0];
  assign e_cnt4  = (m.cnt > 15) ? 32'd15 : m.cnt[31:0];

  // Every-cycle compare, mid-cycle while inputs and state are stable.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("pc_we",       {31'd0, o_pc_we},       {31'd0, e_adv & ~i_hz_stall});
      check("if_id_we",    {31'd0, o_if_id_we},    {31'd0, e_adv & ~i_hz_stall});
      check("if_id_flush", {31'd0, o_if_id_flush}, {31'd0, e_adv & i_hz_flush_if_id});
      check("id_ex_we",    {31'd0, o_id_ex_we},    {31'd0, e_adv | e_drn});
      check("id_ex_flush", {31'd0, o_id_ex_flush}, {31'd0, (e_adv & i_hz_flush_id_ex) | e_drn});
      check("ex_mem_we",   {31'd0, o_ex_mem_we},   {31'd0, e_adv | e_drn});
      check("mem_wb_we",   {31'd0, o_mem_wb_we},   {31'd0, e_adv | e_drn});
      check("busy",        {31'd0, o_busy},        {31'd0, e_adv | e_drn});
      check("halted",      {31'd0, o_halted},      {31'd0, m.done});
      check("state",       {29'd0, o_state},       {29'd0, e_state});
      check("count",       o_cycle_count,          e_cnt32);
      check("count4",      {28'd0, s_cycle_count}, e_cnt4);
      check("state4",      {29'd0, s_state},       {29'd0, e_state});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit run, input bit step, input bit stall, input bit fif,
                        input bit fie, input bit halt);
    i_run = run; i_step = step; i_hz_stall = stall;
    i_hz_flush_if_id = fif; i_hz_flush_id_ex = fie; i_hz_halt = halt;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic cyc(input bit run, input bit step, input bit stall, input bit fif,
                     input bit fie, input bit halt);
    set_in(run, step, stall, fif, fie, halt);
    tick();
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    i_reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk_en = 1'b1;

    check("rst_state",  {29'd0, o_state}, 32'd0);
    check("rst_count",  o_cycle_count, 32'd0);
    check("rst_halted", {31'd0, o_halted}, 32'd0);

    // Single step, then a held step that must produce just one more step.
    cyc(0, 1, 0, 0, 0, 0);
    check("step_state", {29'd0, o_state}, 32'd2);
    cyc(0, 0, 0, 0, 0, 0);
    check("step_back_idle", {29'd0, o_state}, 32'd0);
    check("step_count1", o_cycle_count, 32'd1);
    repeat (5) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("held_step_count", o_cycle_count, 32'd2);

    // Load-use hazard in RUN.
    cyc(1, 0, 0, 0, 0, 0);
    set_in(0, 0, 1, 0, 1, 0);
    #1;
    check("lu_pc_we",     {31'd0, o_pc_we},       32'd0);
    check("lu_if_id_we",  {31'd0, o_if_id_we},    32'd0);
    check("lu_id_ex_fl",  {31'd0, o_id_ex_flush}, 32'd1);
    check("lu_ex_mem_we", {31'd0, o_ex_mem_we},   32'd1);
    tick();
    check("lu_count", o_cycle_count, 32'd3);

    // HALT during the 10th RUN cycle, 3-cycle drain, then DONE at count 13.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      check("drain_state", {29'd0, o_state}, 32'd3);
      check("drain_pc_we", {31'd0, o_pc_we}, 32'd0);
      check("drain_id_ex_flush", {31'd0, o_id_ex_flush}, 32'd1);
      check("drain_mem_wb_we", {31'd0, o_mem_wb_we}, 32'd1);
      tick();
    end
    check("done_state",  {29'd0, o_state}, 32'd4);
    check("done_halted", {31'd0, o_halted}, 32'd1);
    check("done_count",  o_cycle_count, 32'd13);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("done_sticky", {29'd0, o_state}, 32'd4);
    check("done_count_hold", o_cycle_count, 32'd13);

    // Priority: run beats step; halt during STEP drains fully.
    do_reset();
    cyc(1, 1, 0, 0, 0, 0);
    check("prio_run", {29'd0, o_state}, 32'd1);
    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      check("step_drain_state", {29'd0, o_state}, 32'd3);
      cyc(1, (i % 2) == 0, 1, 1, 0, 1);
    end
    check("step_drain_done", {29'd0, o_state}, 32'd4);
    check("step_drain_count", o_cycle_count, 32'd4);

    // Asynchronous reset mid-RUN at count 7.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, 0, 0, 0);
    check("pre_rst_count", o_cycle_count, 32'd7);
    i_reset = 1'b1;
    #1;
    check("async_state", {29'd0, o_state}, 32'd0);
    check("async_pc_we", {31'd0, o_pc_we}, 32'd0);
    check("async_ex_mem_we", {31'd0, o_ex_mem_we}, 32'd0);
    check("async_count", o_cycle_count, 32'd0);
    check("async_busy", {31'd0, o_busy}, 32'd0);
    tick();
    i_reset = 1'b0;

    // Saturation of the 4-bit counter.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, 0, 0);
    check("sat_count4", {28'd0, s_cycle_count}, 32'd15);
    check("sat_count32", o_cycle_count, 32'd20);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    check("sat_hold", {28'd0, s_cycle_count}, 32'd15);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
